l2_tlb_refill: RTL and testbench
================================

# l2_tlb_refill

Write-side controller for the L2 TLB tag RAM: it accepts refill, programming and flush commands and drives the RAM write port. The lookup engine reads the same RAM. Entries are packed in the layout the lookup engine decodes. Auto-refills get a replacement way from a per-set round-robin pointer. A write never lands in a cycle in which a search is active.

## Interface
Parameters:
- ADDR_WIDTH, 32: virtual address width.
- PAGE_SIZE, 4096: page size in bytes. IGNORE_LSB = log2(PAGE_SIZE).
- SET_WIDTH, 5: set index width.
- OFFSET_WIDTH, 4: low way-index width. Each set has 2^(OFFSET_WIDTH+1) ways.
- RAM_DATA_WIDTH, 24: entry width. Must equal ADDR_WIDTH-IGNORE_LSB+4.

Ports (IW = SET_WIDTH+OFFSET_WIDTH+1):
- clk_i  in  1  clock; the block has one clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  command ready.
- req_cmd_i  in  2  command: 00 WRITE_IDX, 01 WRITE_AUTO, 10 FLUSH, 11 reserved.
- req_idx_i  in  IW  RAM address for WRITE_IDX.
- req_vaddr_i  in  ADDR_WIDTH  virtual address of the page.
- req_master_i, req_wen_i, req_ren_i  in  1 each  entry attributes.
- search_active_i  in  1  a lookup is reading the RAM.
- busy_o  out  1  command in progress; the lookup engine starts no new search while high.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  IW  RAM address.
- ram_wdata_o  out  RAM_DATA_WIDTH  RAM write data.
- done_valid_o  out  1  one-cycle completion pulse.
- done_idx_o  out  IW  RAM address written by the completed command.
- done_err_o  out  1  completed command was reserved.

## Operation
- Entry format: [RAM_DATA_WIDTH-1:4] = vaddr[ADDR_WIDTH-1:IGNORE_LSB]; [3] master; [2] write allowed; [1] read allowed; [0] valid = 1.
- Address map: for set s and way w (OFFSET_WIDTH+1 bits), address = {w[OFFSET_WIDTH], s, w[OFFSET_WIDTH-1:0]}.
- All request fields are registered on handshake (req_valid_i && req_ready_o).
- FSM states:
  - IDLE: req_ready_o=1, busy_o=0.
  - WAIT: hold while search_active_i=1.
  - WRITE: one cycle; ram_we_o=1 with registered address and data.
  - FLUSH: sweep all addresses.
  - DONE: done_valid_o=1 for one cycle, then IDLE.
- Transitions:
  - WRITE_IDX or WRITE_AUTO: IDLE→WAIT→WRITE→DONE.
  - FLUSH: IDLE→FLUSH→DONE.
  - Reserved: IDLE→DONE with done_err_o=1; no RAM write.
- WRITE_IDX: address = req_idx_i. Replacement pointers are unchanged.
- WRITE_AUTO:
  - s = vaddr[IGNORE_LSB +: SET_WIDTH]; w = ptr[s].
  - ptr[s] increments modulo 2^(OFFSET_WIDTH+1) in the WRITE cycle.
  - Duplicates are not checked; duplicate avoidance is the requester's job.
- FLUSH:
  - 10-bit (IW) counter from 0 to 2^IW-1; one write of 0 per cycle in which search_active_i=0.
  - While search_active_i=1: ram_we_o=0 and the counter holds.
  - All ptr entries clear to 0 in the first FLUSH cycle.
  - done_idx_o = 0.
- done_idx_o, done_err_o: valid only with done_valid_o; 0 otherwise.

## Timing
- Reset values:
  - req_ready_o=1; busy_o=0.
  - ram_we_o=0; ram_addr_o=0; ram_wdata_o=0.
  - done_valid_o=0; done_idx_o=0; done_err_o=0.
  - All ptr=0; FSM in IDLE.
- Cycle numbering: handshake in cycle 0.
  - busy_o=1 from cycle 1 until the DONE cycle inclusive.
  - req_ready_o=0 in the same cycles.
- Write latency: if search_active_i=0 in cycle 1, ram_we_o=1 in cycle 2 and done_valid_o=1 in cycle 3. The next handshake is possible in cycle 4.
- Search stall: the WAIT→WRITE decision uses search_active_i of the current cycle. The write occurs the cycle after search_active_i is first seen low.
- ram_we_o is never 1 in a cycle following a cycle with search_active_i=1.
- Reserved command: done_valid_o=1, done_err_o=1 in cycle 1.
- FLUSH length: 2^IW + (stall cycles) write-phase cycles, then one DONE cycle.
- Pointer wrap: after way 2^(OFFSET_WIDTH+1)-1, the next WRITE_AUTO to that set uses way 0.
- Reset mid-operation: immediate abort; all outputs take reset values. No done pulse; RAM contents partially written.

## Test plan
- WRITE_IDX, idx=0x123, vaddr=0xABCDE000, master=1, wen=0, ren=1 -> ram_we_o pulse in cycle 2, ram_addr_o=0x123, ram_wdata_o=0xABCDEB; cycle 3 done_idx_o=0x123, done_err_o=0.
- 33× WRITE_AUTO with vaddr=0x00003000 (set 3) -> way 0 at 0x030, way 15 at 0x03F, way 16 at 0x230, way 31 at 0x23F, 33rd write at 0x030.
- search_active_i high for 5 cycles starting at handshake -> no ram_we_o in those cycles; write exactly one cycle after it falls; then done.
- FLUSH with a 3-cycle search_active_i pulse at counter 0x200 -> 1024 writes of 0 to 0x000..0x3FF in order; 3-cycle gap; done_idx_o=0. A following WRITE_AUTO to set 3 writes 0x030.
- req_cmd_i=11 -> no ram_we_o; done_valid_o=1 with done_err_o=1 in cycle 1; req_ready_o=1 in cycle 2.
- rst_ni low while FLUSH is at address 0x100 -> all outputs at reset values while low. After release: req_ready_o=1, no done pulse, all pointers 0.

Source files
------------

// File: rtl/l2_tlb_refill_if.sv
// Command and RAM-write bundle between the L2 TLB write controller and its requester.
// Signal suffixes are from the controller's point of view.
interface l2_tlb_refill_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int SET_WIDTH      = 5,
  parameter int OFFSET_WIDTH   = 4,
  parameter int RAM_DATA_WIDTH = 24
);
  localparam int IW = SET_WIDTH + OFFSET_WIDTH + 1;

  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [1:0]                req_cmd_i;
  logic [IW-1:0]             req_idx_i;
  logic [ADDR_WIDTH-1:0]     req_vaddr_i;
  logic                      req_master_i;
  logic                      req_wen_i;
  logic                      req_ren_i;
  logic                      search_active_i;
  logic                      busy_o;
  logic                      ram_we_o;
  logic [IW-1:0]             ram_addr_o;
  logic [RAM_DATA_WIDTH-1:0] ram_wdata_o;
  logic                      done_valid_o;
  logic [IW-1:0]             done_idx_o;
  logic                      done_err_o;

  modport slave (
    input  req_valid_i, req_cmd_i, req_idx_i, req_vaddr_i,
           req_master_i, req_wen_i, req_ren_i, search_active_i,
    output req_ready_o, busy_o, ram_we_o, ram_addr_o, ram_wdata_o,
           done_valid_o, done_idx_o, done_err_o
  );

  modport master (
    output req_valid_i, req_cmd_i, req_idx_i, req_vaddr_i,
           req_master_i, req_wen_i, req_ren_i, search_active_i,
    input  req_ready_o, busy_o, ram_we_o, ram_addr_o, ram_wdata_o,
           done_valid_o, done_idx_o, done_err_o
  );
endinterface

// File: rtl/l2_tlb_refill.sv
// L2 TLB tag-RAM write controller: indexed/auto refills with per-set round-robin
// replacement and a full flush sweep, never writing right after a search cycle.
module l2_tlb_refill #(
  parameter int ADDR_WIDTH     = 32,
  parameter int PAGE_SIZE      = 4096,
  parameter int SET_WIDTH      = 5,
  parameter int OFFSET_WIDTH   = 4,
  parameter int RAM_DATA_WIDTH = 24
) (
  input logic            clk_i,
  input logic            rst_ni,
  l2_tlb_refill_if.slave bus
);
  localparam int IGNORE_LSB = $clog2(PAGE_SIZE);
  localparam int IW         = SET_WIDTH + OFFSET_WIDTH + 1;
  localparam int PW         = OFFSET_WIDTH + 1;
  localparam int NSETS      = 1 << SET_WIDTH;
  localparam int VPN_W      = ADDR_WIDTH - IGNORE_LSB;

  localparam logic [1:0] CMD_IDX   = 2'b00;
  localparam logic [1:0] CMD_AUTO  = 2'b01;
  localparam logic [1:0] CMD_FLUSH = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e                    state_q;
  logic                      ready_q;
  logic                      busy_q;
  logic                      we_q;
  logic [IW-1:0]             addr_q;
  logic [RAM_DATA_WIDTH-1:0] wdata_q;
  logic                      done_q;
  logic [IW-1:0]             didx_q;
  logic                      derr_q;
  logic [PW-1:0]             ptr_q [NSETS];

  logic [1:0]                cmd_q;
  logic [IW-1:0]             idx_q;
  logic [VPN_W-1:0]          vpn_q;
  logic                      master_q;
  logic                      wen_q;
  logic                      ren_q;

  logic                      hs;
  logic [SET_WIDTH-1:0]      set_d;
  logic [PW-1:0]             way_d;
  logic [IW-1:0]             tgt_d;
  logic [RAM_DATA_WIDTH-1:0] entry_d;

  assign hs      = bus.req_valid_i & ready_q;
  assign set_d   = vpn_q[SET_WIDTH-1:0];
  assign way_d   = ptr_q[set_d];
  // The way MSB sits above the set index so the two way halves form separate banks.
  assign tgt_d   = (cmd_q == CMD_AUTO) ? {way_d[PW-1], set_d, way_d[PW-2:0]} : idx_q;
  assign entry_d = {vpn_q, master_q, wen_q, ren_q, 1'b1};

  assign bus.req_ready_o  = ready_q;
  assign bus.busy_o       = busy_q;
  assign bus.ram_we_o     = we_q;
  assign bus.ram_addr_o   = addr_q;
  assign bus.ram_wdata_o  = wdata_q;
  assign bus.done_valid_o = done_q;
  assign bus.done_idx_o   = didx_q;
  assign bus.done_err_o   = derr_q;

  // Request capture: pure data, no reset needed.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      cmd_q    <= bus.req_cmd_i;
      idx_q    <= bus.req_idx_i;
      vpn_q    <= bus.req_vaddr_i[ADDR_WIDTH-1:IGNORE_LSB];
      master_q <= bus.req_master_i;
      wen_q    <= bus.req_wen_i;
      ren_q    <= bus.req_ren_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      didx_q  <= '0;
      derr_q  <= 1'b0;
      for (int i = 0; i < NSETS; i++) ptr_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hs) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            case (bus.req_cmd_i)
              CMD_IDX, CMD_AUTO: state_q <= S_WAIT;
              CMD_FLUSH: begin
                state_q <= S_FLUSH;
                addr_q  <= '0;
                wdata_q <= '0;
                we_q    <= ~bus.search_active_i;
              end
              default: begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                derr_q  <= 1'b1;
                didx_q  <= '0;
              end
            endcase
          end
        end
        S_WAIT: begin
          if (!bus.search_active_i) begin
            state_q <= S_WRITE;
            we_q    <= 1'b1;
            addr_q  <= tgt_d;
            wdata_q <= entry_d;
          end
        end
        S_WRITE: begin
          state_q <= S_DONE;
          we_q    <= 1'b0;
          done_q  <= 1'b1;
          didx_q  <= addr_q;
          if (cmd_q == CMD_AUTO) ptr_q[set_d] <= way_d + PW'(1);
        end
        S_FLUSH: begin
          for (int i = 0; i < NSETS; i++) ptr_q[i] <= '0;
          // addr_q doubles as the sweep counter; it only advances after a real write.
          if (we_q && (addr_q == {IW{1'b1}})) begin
            state_q <= S_DONE;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            didx_q  <= '0;
          end else begin
            if (we_q) addr_q <= addr_q + IW'(1);
            we_q <= ~bus.search_active_i;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          didx_q  <= '0;
          derr_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_tlb_refill.sv
// Bench for l2_tlb_refill: directed timing cases plus randomized traffic checked
// against a queue-based model of expected RAM writes and completions.
module tb_l2_tlb_refill;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  l2_tlb_refill_if bus ();
  l2_tlb_refill dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int   total = 0;
  int   bad   = 0;
  int   ew_addr[$];
  int   ew_data[$];
  int   ed_idx[$];
  int   ed_err[$];
  int   wlog[$];
  int   mptr[32];
  logic prev_search = 1'b0;
  logic rnd_en = 1'b0;
  int   nflush = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_stop(input string what);
    total++;
    bad++;
    $display("FAIL %s: no response within cycle budget", what);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench aborted");
  endtask

  function automatic void model_reset();
    ew_addr.delete(); ew_data.delete(); ed_idx.delete(); ed_err.delete();
    for (int i = 0; i < 32; i++) mptr[i] = 0;
  endfunction

  // Expected effect of an accepted command, from the entry format and address map.
  function automatic void model_accept(input logic [1:0] cmd, input logic [9:0] idx,
                                       input logic [31:0] va, input logic m,
                                       input logic w, input logic r);
    int e, s, wy, a;
    e = int'(va >> 12) * 16 + (m ? 8 : 0) + (w ? 4 : 0) + (r ? 2 : 0) + 1;
    case (cmd)
      2'b00: begin
        ew_addr.push_back(int'(idx)); ew_data.push_back(e);
        ed_idx.push_back(int'(idx));  ed_err.push_back(0);
      end
      2'b01: begin
        s  = int'((va >> 12) % 32);
        wy = mptr[s];
        a  = (wy / 16) * 512 + s * 16 + (wy % 16);
        mptr[s] = (wy + 1) % 32;
        ew_addr.push_back(a); ew_data.push_back(e);
        ed_idx.push_back(a);  ed_err.push_back(0);
      end
      2'b10: begin
        for (int i = 0; i < 1024; i++) begin
          ew_addr.push_back(i); ew_data.push_back(0);
        end
        for (int i = 0; i < 32; i++) mptr[i] = 0;
        ed_idx.push_back(0); ed_err.push_back(0);
      end
      default: begin
        ed_idx.push_back(0); ed_err.push_back(1);
      end
    endcase
  endfunction

  task automatic send(input logic [1:0] cmd, input logic [9:0] idx, input logic [31:0] va,
                      input logic m, input logic w, input logic r);
    int n = 0;
    bus.req_valid_i  = 1'b1;
    bus.req_cmd_i    = cmd;
    bus.req_idx_i    = idx;
    bus.req_vaddr_i  = va;
    bus.req_master_i = m;
    bus.req_wen_i    = w;
    bus.req_ren_i    = r;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_ready_o !== 1'b1 && n < 5000);
    if (bus.req_ready_o !== 1'b1) fail_stop("send_ready");
    model_accept(cmd, idx, va, m, w, r);
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    bus.req_idx_i   = 10'($urandom);
    bus.req_vaddr_i = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_ready_o !== 1'b1 && n < 5000);
    if (bus.req_ready_o !== 1'b1) fail_stop("wait_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
    chk({tag, "_busy"},  32'(bus.busy_o), 32'd0);
    chk({tag, "_we"},    32'(bus.ram_we_o), 32'd0);
    chk({tag, "_addr"},  32'(bus.ram_addr_o), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.ram_wdata_o), 32'd0);
    chk({tag, "_done"},  32'(bus.done_valid_o), 32'd0);
    chk({tag, "_didx"},  32'(bus.done_idx_o), 32'd0);
    chk({tag, "_derr"},  32'(bus.done_err_o), 32'd0);
  endtask

  // Every-cycle comparison of the write port and completion against the model queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("ready_vs_busy", 32'(bus.req_ready_o), 32'(!bus.busy_o));
      if (bus.ram_we_o === 1'b1) begin
        chk("we_after_search", 32'(prev_search), 32'd0);
        wlog.push_back(int'(bus.ram_addr_o));
        if (ew_addr.size() == 0) chk("unexpected_write", 32'(bus.ram_we_o), 32'd0);
        else begin
          chk("wr_addr", 32'(bus.ram_addr_o), 32'(ew_addr.pop_front()));
          chk("wr_data", 32'(bus.ram_wdata_o), 32'(ew_data.pop_front()));
        end
      end
      if (bus.done_valid_o === 1'b1) begin
        if (ed_idx.size() == 0) chk("unexpected_done", 32'(bus.done_valid_o), 32'd0);
        else begin
          chk("done_idx", 32'(bus.done_idx_o), 32'(ed_idx.pop_front()));
          chk("done_err", 32'(bus.done_err_o), 32'(ed_err.pop_front()));
        end
      end else begin
        chk("idle_done_idx", 32'(bus.done_idx_o), 32'd0);
        chk("idle_done_err", 32'(bus.done_err_o), 32'd0);
      end
    end
    prev_search = bus.search_active_i;
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      bus.search_active_i = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #900000;
    fail_stop("watchdog");
  end

  initial begin
    int   k, nw, gap, done_k, didx_seen, n;
    logic nxt;
    int   sched;
    bus.req_valid_i = 1'b0; bus.req_cmd_i = 2'b00; bus.req_idx_i = '0;
    bus.req_vaddr_i = '0; bus.req_master_i = 1'b0; bus.req_wen_i = 1'b0;
    bus.req_ren_i = 1'b0; bus.search_active_i = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // WRITE_IDX latency and entry packing
    wait_idle();
    send(2'b00, 10'h123, 32'hABCDE000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("A_busy_c1", 32'(bus.busy_o), 32'd1);
    chk("A_ready_c1", 32'(bus.req_ready_o), 32'd0);
    chk("A_we_c1", 32'(bus.ram_we_o), 32'd0);
    @(negedge clk);
    chk("A_we_c2", 32'(bus.ram_we_o), 32'd1);
    chk("A_addr_c2", 32'(bus.ram_addr_o), 32'h123);
    chk("A_data_c2", 32'(bus.ram_wdata_o), 32'hABCDEB);
    @(negedge clk);
    chk("A_done_c3", 32'(bus.done_valid_o), 32'd1);
    chk("A_didx_c3", 32'(bus.done_idx_o), 32'h123);
    chk("A_derr_c3", 32'(bus.done_err_o), 32'd0);
    @(negedge clk);
    chk("A_ready_c4", 32'(bus.req_ready_o), 32'd1);

    // Round-robin over all 32 ways of set 3, then wrap
    wait_idle();
    wlog.delete();
    for (int i = 0; i < 33; i++) send(2'b01, 10'h0, 32'h00003000, 1'b0, 1'b1, 1'b1);
    wait_idle();
    chk("B_count", 32'(wlog.size()), 32'd33);
    chk("B_way0", 32'(wlog[0]), 32'h030);
    chk("B_way15", 32'(wlog[15]), 32'h03F);
    chk("B_way16", 32'(wlog[16]), 32'h230);
    chk("B_way31", 32'(wlog[31]), 32'h23F);
    chk("B_wrap", 32'(wlog[32]), 32'h030);

    // Search stall: active in cycles 0..4
    bus.search_active_i = 1'b1;
    send(2'b00, 10'h2A5, 32'h12345000, 1'b0, 1'b1, 1'b1);
    for (int kk = 1; kk <= 7; kk++) begin
      @(negedge clk);
      if (kk <= 5) chk("C_no_we", 32'(bus.ram_we_o), 32'd0);
      if (kk == 6) begin
        chk("C_we", 32'(bus.ram_we_o), 32'd1);
        chk("C_addr", 32'(bus.ram_addr_o), 32'h2A5);
      end
      if (kk == 7) chk("C_done", 32'(bus.done_valid_o), 32'd1);
      if (kk == 4) begin
        @(posedge clk);
        #1 bus.search_active_i = 1'b0;
      end
    end

    // Flush with a 3-cycle search pulse once address 0x1FF has been written
    wait_idle();
    send(2'b10, 10'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    k = 0; nw = 0; gap = 0; done_k = 0; didx_seen = -1; sched = 0;
    while (done_k == 0 && k < 3000) begin
      @(negedge clk);
      k++;
      if (bus.ram_we_o === 1'b1) begin
        nw++;
        if (bus.ram_addr_o == 10'h1FF) sched = 3;
      end else if (bus.done_valid_o !== 1'b1 && nw > 0 && nw < 1024) gap++;
      if (bus.done_valid_o === 1'b1) begin
        done_k = k;
        didx_seen = int'(bus.done_idx_o);
      end
      nxt = (sched > 0);
      if (sched > 0) sched--;
      @(posedge clk);
      #1 bus.search_active_i = nxt;
    end
    bus.search_active_i = 1'b0;
    chk("D_writes", 32'(nw), 32'd1024);
    chk("D_gap", 32'(gap), 32'd3);
    chk("D_done_cycle", 32'(done_k), 32'd1028);
    chk("D_done_idx", 32'(didx_seen), 32'd0);
    wait_idle();
    wlog.delete();
    send(2'b01, 10'h0, 32'h00003000, 1'b1, 1'b1, 1'b1);
    wait_idle();
    chk("D_ptr_cleared", 32'(wlog[0]), 32'h030);

    // Reserved command
    send(2'b11, 10'h3FF, 32'hFFFFF000, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("E_done", 32'(bus.done_valid_o), 32'd1);
    chk("E_err", 32'(bus.done_err_o), 32'd1);
    chk("E_we", 32'(bus.ram_we_o), 32'd0);
    chk("E_busy", 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    chk("E_ready_c2", 32'(bus.req_ready_o), 32'd1);
    chk("E_done_c2", 32'(bus.done_valid_o), 32'd0);

    // Reset in the middle of a flush
    wait_idle();
    send(2'b10, 10'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.ram_we_o === 1'b1 && bus.ram_addr_o == 10'h100) && n < 2000);
    if (n >= 2000) fail_stop("F_reach_0x100");
    rst_n = 1'b0;
    model_reset();
    #1 chk_reset_outputs("F_assert");
    repeat (2) @(negedge clk);
    chk_reset_outputs("F_hold");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int kk = 0; kk < 3; kk++) begin
      @(negedge clk);
      chk("F_no_done", 32'(bus.done_valid_o), 32'd0);
      chk("F_ready", 32'(bus.req_ready_o), 32'd1);
    end

    // Reset must clear replacement pointers
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(2'b01, 10'h0, 32'h00007000, 1'b0, 1'b0, 1'b1);
    wait_idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    wlog.delete();
    send(2'b01, 10'h0, 32'h00007000, 1'b0, 1'b0, 1'b1);
    wait_idle();
    chk("G_ptr_after_reset", 32'(wlog[0]), 32'h070);

    // Randomized traffic with random search activity
    rnd_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] va;
      int          c;
      logic [1:0]  cmd;
      c = int'($urandom_range(0, 99));
      if (c < 45) cmd = 2'b00;
      else if (c < 88) cmd = 2'b01;
      else if (c < 93 && nflush < 2) begin
        cmd = 2'b10;
        nflush++;
      end else cmd = 2'b11;
      va = $urandom;
      va[16:12] = 5'($urandom_range(0, 3));
      send(cmd, 10'($urandom), va, 1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rnd_en = 1'b0;
    @(posedge clk);
    #2 bus.search_active_i = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("H_pending_writes", 32'(ew_addr.size()), 32'd0);
    chk("H_pending_dones", 32'(ed_idx.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
